// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle 32-bit RISC core: sequences fetch/decode/execute/memory/wb.
// Optional ADDI support is enabled by defining CTRL_ADDI_EN.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef CTRL_ADDI_EN
  localparam logic [5:0] OpAddi  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9
`ifdef CTRL_ADDI_EN
    ,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
`endif
  } state_e;

  state_e state_q, state_d;

  logic       pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic       mem_to_reg_c, reg_dst_c, reg_write_c, alu_src_a_c, instr_done_c, illegal_c;
  logic [1:0] pc_source_c, alu_src_b_c, alu_op_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = StFetch;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_source_c     = 2'b00;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 2'b00;
    instr_done_c    = 1'b0;
    illegal_c       = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        state_d     = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_b_c = 2'b11;
        case (opcode)
          OpLw, OpSw: state_d = StMemAddr;
          OpRtype:    state_d = StRExec;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
`ifdef CTRL_ADDI_EN
          OpAddi:     state_d = StAddiExec;
`endif
          default: begin
            illegal_c    = 1'b1;
            instr_done_c = 1'b1;
            state_d      = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        if (opcode == OpLw) begin
          state_d = StMemRd;
        end else if (opcode == OpSw) begin
          state_d = StMemWr;
        end else begin
          state_d = StFetch;
        end
      end
      StMemRd: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        state_d    = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        mem_to_reg_c = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      StMemWr: begin
        mem_write_c  = 1'b1;
        i_or_d_c     = 1'b1;
        instr_done_c = mem_ready;
        state_d      = mem_ready ? StFetch : StMemWr;
      end
      StRExec: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = StRWb;
      end
      StRWb: begin
        reg_dst_c    = 1'b1;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
      StBranch: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'b01;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'b01;
        instr_done_c    = 1'b1;
      end
      StJump: begin
        pc_write_c   = 1'b1;
        pc_source_c  = 2'b10;
        instr_done_c = 1'b1;
      end
`ifdef CTRL_ADDI_EN
      StAddiExec: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = StAddiWb;
      end
      StAddiWb: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
      end
`endif
      default: state_d = StFetch;
    endcase
  end

  // Reset gates every output combinationally, independent of the state register.
  assign pc_write      = rst_n & pc_write_c;
  assign pc_write_cond = rst_n & pc_write_cond_c;
  assign pc_source     = rst_n ? pc_source_c : 2'b00;
  assign i_or_d        = rst_n & i_or_d_c;
  assign mem_read      = rst_n & mem_read_c;
  assign mem_write     = rst_n & mem_write_c;
  assign ir_write      = rst_n & ir_write_c;
  assign mem_to_reg    = rst_n & mem_to_reg_c;
  assign reg_dst       = rst_n & reg_dst_c;
  assign reg_write     = rst_n & reg_write_c;
  assign alu_src_a     = rst_n & alu_src_a_c;
  assign alu_src_b     = rst_n ? alu_src_b_c : 2'b00;
  assign alu_op        = rst_n ? alu_op_c : 2'b00;
  assign instr_done    = rst_n & instr_done_c;
  assign illegal       = rst_n & illegal_c;
  assign state         = rst_n ? state_q : 4'd0;

endmodule
